finish_screen_fx: RTL and testbench
===================================

// Module: finish_screen_fx
// PURPOSE
//  Parametrised end-of-game overlay stage in the vga_if pipeline, sitting after the game draw stages.
//  Passes the incoming picture through when idle; when enabled it draws a bordered box over it.
//  The box is shown with a frame-synchronous vertical reveal (wipe-open from its centre row),
//  then holds static or blinks. Timing passes through with one cycle of latency.
// PARAMETERS
//  BOX_X         300      left edge of box, pixels
//  BOX_Y         225      top edge of box, lines
//  BOX_W         200      box width, pixels (>=2*BORDER_W+1)
//  BOX_H         150      box height, lines; must be even (elaboration assertion)
//  BORDER_W      4        border thickness, pixels/lines; 0 = no border
//  BOX_RGB       12'h0f0  box fill colour
//  BORDER_RGB    12'hfff  border colour
//  REVEAL_STEP   5        half-height growth per frame, lines (>=1)
//  MODE          FX_BLINK FX_STATIC or FX_BLINK (fx_mode_t)
//  BLINK_FRAMES  30       frames per blink half-period (>=1)
// PORTS
//  clk      in   1   pixel clock
//  rst      in   1   asynchronous reset, active-low
//  enable   in   1   level request to show overlay; sampled only on frame_tick
//  active   out  1   1 when state != FX_IDLE
//  shown    out  1   1 once reveal is complete (FX_SHOW)
//  vga_in   vga_if.in   vcount/hcount[10:0], vsync, vblnk, hsync, hblnk, rgb[11:0]
//  vga_out  vga_if.out  same fields, registered
// BEHAVIOUR
//  Reset (rst low, async): all vga_out fields 0, active=0, shown=0, state FX_IDLE,
//   reveal_h=0, blink_cnt=0, blink_on=1, vblnk_d=0.
//  Latency: every vga_out field = vga_in field one clk earlier; rgb computed from same-cycle vga_in.
//  frame_tick: vga_in.vblnk rising edge (vblnk & ~vblnk_d); state/counters change only on it.
//  rgb priority: vblnk|hblnk -> 12'h000; else overlay pixel -> BORDER_RGB/BOX_RGB; else vga_in.rgb.
//   rgb_nxt is fully assigned on every path (no latch).
//  Geometry: cy = BOX_Y + BOX_H/2; row visible iff cy-reveal_h <= vcount < cy+reveal_h
//   and BOX_Y<=vcount<BOX_Y+BOX_H; column iff BOX_X<=hcount<BOX_X+BOX_W.
//   Border = visible pixel within BORDER_W of box edge (box edges, not reveal edges).
//  States (fx_state_t), evaluated at frame_tick:
//   FX_IDLE:   enable -> FX_REVEAL, reveal_h=REVEAL_STEP (saturated at BOX_H/2). Overlay off.
//   FX_REVEAL: !enable -> FX_IDLE, reveal_h=0. Else reveal_h += REVEAL_STEP, saturate at BOX_H/2;
//              reaching BOX_H/2 -> FX_SHOW, blink_cnt=0, blink_on=1.
//   FX_SHOW:   !enable -> FX_IDLE, reveal_h=0. MODE=FX_BLINK: blink_cnt++; at BLINK_FRAMES-1
//              wraps to 0 and toggles blink_on. MODE=FX_STATIC: blink_on held 1.
//              Overlay drawn only when blink_on=1.
//  reveal_h arithmetic 11-bit unsigned, saturating; never exceeds BOX_H/2.
//  enable changing mid-frame has no visible effect until next frame_tick (no tearing).
//  enable high at the same frame_tick that reveal completes: FX_SHOW entered; low: FX_IDLE wins.
//  REVEAL_STEP >= BOX_H/2: reveal completes on the first tick (IDLE->REVEAL, next tick ->SHOW).
//  active/shown registered, updated with state; shown=1 only in FX_SHOW.
//  Reset asserted mid-frame: outputs clear immediately; after release the overlay restarts from FX_IDLE.
// STRUCTURE
//  vga_pkg gains: typedef enum logic[1:0] {FX_IDLE,FX_REVEAL,FX_SHOW} fx_state_t;
//   typedef enum logic {FX_STATIC,FX_BLINK} fx_mode_t; existing HOR/VER timing constants reused.
//  One sub-module: edge_rise (1-bit registered rising-edge detector, async active-low reset),
//   used for frame_tick. All other logic stays in finish_screen_fx.
// TESTING (vga timing generator 800x600 as stimulus; scoreboard on vga_out)
//  1 Reset mid-line, enable=0 -> vga_out all 0 during reset; after release vga_out==vga_in delayed 1 clk,
//    rgb 000 in blanking, active=0.
//  2 enable=1 mid-frame, REVEAL_STEP=5 -> no change until next vblnk rise; following frame rows
//    295..304 (cy=300) coloured at hcount 300..499; after 15 frames shown=1, rows 225..374 drawn.
//  3 Pixel check in FX_SHOW: (302,230) -> 12'hfff border; (400,300) -> 12'h0f0; (299,300) -> vga_in.rgb.
//  4 MODE=FX_BLINK, BLINK_FRAMES=30 -> box visible 30 frames, absent 30, visible again; shown stays 1.
//  5 enable dropped during FX_REVEAL and during FX_SHOW -> FX_IDLE at next frame_tick, active=0,
//    re-enable restarts reveal from REVEAL_STEP.
//  6 REVEAL_STEP=200 (>=75) -> REVEAL then SHOW on consecutive ticks; reveal_h never exceeds 75.

Source files
------------

// File: rtl/finish_screen_fx_pkg.sv
// Shared types and VGA timing constants for the finish-screen overlay stage.
package finish_screen_fx_pkg;

  typedef enum logic [1:0] {FX_IDLE, FX_REVEAL, FX_SHOW} fx_state_t;
  typedef enum logic {FX_STATIC, FX_BLINK} fx_mode_t;

  localparam int VGA_CW          = 11;
  localparam int VGA_RGBW        = 12;
  localparam int HOR_TOTAL_TIME  = 1056;
  localparam int HOR_BLANK_START = 800;
  localparam int VER_TOTAL_TIME  = 628;
  localparam int VER_BLANK_START = 600;

endpackage

// File: rtl/finish_screen_fx_edge_rise.sv
// Registered rising-edge detector; rise_o is high in the cycle d_i first reads 1.
module edge_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) d_q <= 1'b0;
    else         d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/finish_screen_fx.sv
// End-of-game overlay: passes the picture through, or draws a bordered box revealed
// from its centre row once per frame, then holds or blinks. One cycle of latency.
module finish_screen_fx
  import finish_screen_fx_pkg::*;
#(
  parameter int          BOX_X        = 300,
  parameter int          BOX_Y        = 225,
  parameter int          BOX_W        = 200,
  parameter int          BOX_H        = 150,
  parameter int          BORDER_W     = 4,
  parameter logic [11:0] BOX_RGB      = 12'h0f0,
  parameter logic [11:0] BORDER_RGB   = 12'hfff,
  parameter int          REVEAL_STEP  = 5,
  parameter fx_mode_t    MODE         = FX_BLINK,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  output logic        active_o,
  output logic        shown_o,
  input  logic [10:0] vcount_i,
  input  logic        vsync_i,
  input  logic        vblnk_i,
  input  logic [10:0] hcount_i,
  input  logic        hsync_i,
  input  logic        hblnk_i,
  input  logic [11:0] rgb_i,
  output logic [10:0] vcount_o,
  output logic        vsync_o,
  output logic        vblnk_o,
  output logic [10:0] hcount_o,
  output logic        hsync_o,
  output logic        hblnk_o,
  output logic [11:0] rgb_o
);

  if (BOX_H % 2 != 0) begin : g_box_h_odd
    $error("finish_screen_fx: BOX_H must be even");
  end

  localparam logic [10:0] HALF     = 11'(BOX_H / 2);
  localparam logic [10:0] STEP_SAT = (REVEAL_STEP >= BOX_H / 2) ? HALF : 11'(REVEAL_STEP);
  localparam logic [11:0] CY       = 12'(BOX_Y + BOX_H / 2);
  localparam logic [10:0] X0       = 11'(BOX_X);
  localparam logic [10:0] X1       = 11'(BOX_X + BOX_W);
  localparam logic [10:0] XB0      = 11'(BOX_X + BORDER_W);
  localparam logic [10:0] XB1      = 11'(BOX_X + BOX_W - BORDER_W);
  localparam logic [10:0] Y0       = 11'(BOX_Y);
  localparam logic [10:0] Y1       = 11'(BOX_Y + BOX_H);
  localparam logic [10:0] YB0      = 11'(BOX_Y + BORDER_W);
  localparam logic [10:0] YB1      = 11'(BOX_Y + BOX_H - BORDER_W);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  fx_state_t   state_q, state_d;
  logic [10:0] reveal_h_q, reveal_h_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;
  logic        active_q, shown_q;
  logic        frame_tick;
  logic [11:0] reveal_sum;
  logic        in_col, in_row, in_reveal, is_border, draw_en;
  logic [11:0] rgb_nxt;

  edge_rise u_frame_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (vblnk_i),
    .rise_o (frame_tick)
  );

  // Both operands are <= HALF, so the 12-bit sum cannot wrap.
  assign reveal_sum = {1'b0, reveal_h_q} + {1'b0, STEP_SAT};

  always_comb begin
    state_d     = state_q;
    reveal_h_d  = reveal_h_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_tick) begin
      case (state_q)
        FX_IDLE: begin
          if (enable_i) begin
            state_d     = FX_REVEAL;
            reveal_h_d  = STEP_SAT;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
          end
        end
        FX_REVEAL: begin
          if (!enable_i) begin
            state_d    = FX_IDLE;
            reveal_h_d = '0;
          end else if (reveal_sum >= {1'b0, HALF}) begin
            state_d     = FX_SHOW;
            reveal_h_d  = HALF;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
          end else begin
            reveal_h_d = reveal_sum[10:0];
          end
        end
        FX_SHOW: begin
          if (!enable_i) begin
            state_d     = FX_IDLE;
            reveal_h_d  = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
          end else if (MODE == FX_BLINK) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              blink_on_d  = ~blink_on_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 16'd1;
            end
          end else begin
            blink_on_d = 1'b1;
          end
        end
        default: begin
          state_d    = FX_IDLE;
          reveal_h_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_col    = (hcount_i >= X0) && (hcount_i < X1);
    in_row    = (vcount_i >= Y0) && (vcount_i < Y1);
    in_reveal = (({1'b0, vcount_i} + {1'b0, reveal_h_q}) >= CY) &&
                ({1'b0, vcount_i} < (CY + {1'b0, reveal_h_q}));
    // Border follows the box outline, not the moving reveal edge.
    is_border = (hcount_i < XB0) || (hcount_i >= XB1) ||
                (vcount_i < YB0) || (vcount_i >= YB1);
    draw_en   = (state_q == FX_REVEAL) || ((state_q == FX_SHOW) && blink_on_q);
    rgb_nxt   = rgb_i;
    if (vblnk_i || hblnk_i) begin
      rgb_nxt = 12'h000;
    end else if (draw_en && in_col && in_row && in_reveal) begin
      rgb_nxt = is_border ? BORDER_RGB : BOX_RGB;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FX_IDLE;
      reveal_h_q  <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      active_q    <= 1'b0;
      shown_q     <= 1'b0;
      vcount_o    <= '0;
      vsync_o     <= 1'b0;
      vblnk_o     <= 1'b0;
      hcount_o    <= '0;
      hsync_o     <= 1'b0;
      hblnk_o     <= 1'b0;
      rgb_o       <= '0;
    end else begin
      state_q     <= state_d;
      reveal_h_q  <= reveal_h_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      active_q    <= (state_d != FX_IDLE);
      shown_q     <= (state_d == FX_SHOW);
      vcount_o    <= vcount_i;
      vsync_o     <= vsync_i;
      vblnk_o     <= vblnk_i;
      hcount_o    <= hcount_i;
      hsync_o     <= hsync_i;
      hblnk_o     <= hblnk_i;
      rgb_o       <= rgb_nxt;
    end
  end

  assign active_o = active_q;
  assign shown_o  = shown_q;

endmodule

// File: tb/tb_finish_screen_fx.sv
// Directed bench: pixels are probed one at a time, frame ticks are single vblnk pulses.
module tb_finish_screen_fx;
  import finish_screen_fx_pkg::*;

  localparam logic [11:0] PASS = 12'h3a5;
  localparam logic [11:0] BOX  = 12'h0f0;
  localparam logic [11:0] BRD  = 12'hfff;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [10:0] vcount_i = '0, hcount_i = '0;
  logic        vsync_i = 1'b0, vblnk_i = 1'b0, hsync_i = 1'b0, hblnk_i = 1'b0;
  logic [11:0] rgb_i = '0;

  logic        active_a, shown_a, vsync_a, vblnk_a, hsync_a, hblnk_a;
  logic [10:0] vcount_a, hcount_a;
  logic [11:0] rgb_a;
  logic        active_b, shown_b, vsync_b, vblnk_b, hsync_b, hblnk_b;
  logic [10:0] vcount_b, hcount_b;
  logic [11:0] rgb_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  finish_screen_fx u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .active_o(active_a), .shown_o(shown_a),
    .vcount_i(vcount_i), .vsync_i(vsync_i), .vblnk_i(vblnk_i), .hcount_i(hcount_i),
    .hsync_i(hsync_i), .hblnk_i(hblnk_i), .rgb_i(rgb_i),
    .vcount_o(vcount_a), .vsync_o(vsync_a), .vblnk_o(vblnk_a), .hcount_o(hcount_a),
    .hsync_o(hsync_a), .hblnk_o(hblnk_a), .rgb_o(rgb_a)
  );

  finish_screen_fx #(.REVEAL_STEP(200), .MODE(FX_STATIC)) u_dut6 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .active_o(active_b), .shown_o(shown_b),
    .vcount_i(vcount_i), .vsync_i(vsync_i), .vblnk_i(vblnk_i), .hcount_i(hcount_i),
    .hsync_i(hsync_i), .hblnk_i(hblnk_i), .rgb_i(rgb_i),
    .vcount_o(vcount_b), .vsync_o(vsync_b), .vblnk_o(vblnk_b), .hcount_o(hcount_b),
    .hsync_o(hsync_b), .hblnk_o(hblnk_b), .rgb_o(rgb_b)
  );

  task automatic probe(input int v, input int h, output logic [11:0] got, output logic [11:0] got6);
    @(negedge clk);
    vcount_i = 11'(v); hcount_i = 11'(h); rgb_i = PASS; hblnk_i = 1'b0; vblnk_i = 1'b0;
    @(negedge clk);
    got = rgb_a; got6 = rgb_b;
  endtask

  task automatic tick();
    @(negedge clk); vblnk_i = 1'b1;
    @(negedge clk); vblnk_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vcount_i = 11'd10; hcount_i = 11'd100; rgb_i = 12'habc; vsync_i = 1'b1; hsync_i = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({vcount_a, hcount_a, vsync_a, vblnk_a, hsync_a, hblnk_a, rgb_a, active_a, shown_a} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%0d h=%0d rgb=%h act=%b shown=%b, want all 0",
                         vcount_a, hcount_a, rgb_a, active_a, shown_a);
    end
    rst_n = 1'b1;
    hcount_i = 11'd101;
    @(negedge clk);
    n_cmp++;
    if ({vcount_a, hcount_a, rgb_a, vsync_a, hsync_a} !== {11'd10, 11'd101, 12'habc, 2'b11}) begin
      n_fail++; $display("FAIL passthrough: got v=%0d h=%0d rgb=%h vs=%b hs=%b, want 10 101 abc 1 1",
                         vcount_a, hcount_a, rgb_a, vsync_a, hsync_a);
    end
    n_cmp++;
    if (active_a !== 1'b0) begin n_fail++; $display("FAIL active_after_reset: got %b want 0", active_a); end
    hblnk_i = 1'b1; rgb_i = 12'hfff; hcount_i = 11'd900;
    @(negedge clk);
    n_cmp++;
    if ({rgb_a, hblnk_a, hcount_a} !== {12'h000, 1'b1, 11'd900}) begin
      n_fail++; $display("FAIL hblank_black: got rgb=%h hb=%b h=%0d want 000 1 900", rgb_a, hblnk_a, hcount_a);
    end
    hblnk_i = 1'b0; vblnk_i = 1'b1; vsync_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rgb_a, vblnk_a, vsync_a} !== {12'h000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL vblank_black: got rgb=%h vb=%b vs=%b want 000 1 0", rgb_a, vblnk_a, vsync_a);
    end
    vblnk_i = 1'b0; hsync_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reveal();
    logic [11:0] g, g6;
    int pv[8]; int ph[8]; logic [11:0] pe[8];
    pv = '{295, 304, 294, 305, 300, 300, 300, 295};
    ph = '{400, 400, 400, 400, 299, 499, 500, 300};
    pe = '{BOX, BOX, PASS, PASS, PASS, BRD, PASS, BRD};
    enable = 1'b1;
    probe(300, 400, g, g6);
    n_cmp++;
    if (g !== PASS || active_a !== 1'b0) begin
      n_fail++; $display("FAIL enable_before_tick: got rgb=%h act=%b want %h 0", g, active_a, PASS);
    end
    tick();
    n_cmp++;
    if ({active_a, shown_a, active_b, shown_b} !== 4'b1010) begin
      n_fail++; $display("FAIL first_tick_flags: got %b%b%b%b want 1010", active_a, shown_a, active_b, shown_b);
    end
    for (int i = 0; i < 8; i++) begin
      probe(pv[i], ph[i], g, g6);
      n_cmp++;
      if (g !== pe[i]) begin
        n_fail++; $display("FAIL reveal5_px(%0d,%0d): got %h want %h", ph[i], pv[i], g, pe[i]);
      end
    end
    probe(225, 400, g, g6);
    n_cmp++;
    if (g6 !== BRD) begin n_fail++; $display("FAIL big_step_full_box: got %h want %h", g6, BRD); end
    tick();
    n_cmp++;
    if (shown_b !== 1'b1 || shown_a !== 1'b0) begin
      n_fail++; $display("FAIL big_step_show_second_tick: got b=%b a=%b want 1 0", shown_b, shown_a);
    end
    for (int i = 3; i <= 14; i++) tick();
    n_cmp++;
    if (shown_a !== 1'b0) begin n_fail++; $display("FAIL shown_at_14: got %b want 0", shown_a); end
    probe(230, 400, g, g6);
    n_cmp++;
    if (g !== BOX) begin n_fail++; $display("FAIL reveal70_row230: got %h want %h", g, BOX); end
    probe(229, 400, g, g6);
    n_cmp++;
    if (g !== PASS) begin n_fail++; $display("FAIL reveal70_row229: got %h want %h", g, PASS); end
    tick();
    n_cmp++;
    if ({active_a, shown_a} !== 2'b11) begin
      n_fail++; $display("FAIL shown_at_15: got act=%b shown=%b want 1 1", active_a, shown_a);
    end
    pv = '{225, 374, 224, 375, 226, 373, 300, 300};
    ph = '{400, 400, 400, 400, 400, 400, 303, 304};
    pe = '{BRD, BRD, PASS, PASS, BRD, BRD, BRD, BOX};
    for (int i = 0; i < 8; i++) begin
      probe(pv[i], ph[i], g, g6);
      n_cmp++;
      if (g !== pe[i]) begin
        n_fail++; $display("FAIL full_box_px(%0d,%0d): got %h want %h", ph[i], pv[i], g, pe[i]);
      end
    end
    n_cmp++;
    if (u_dut6.reveal_h_q > 11'd75) begin
      n_fail++; $display("FAIL reveal_h_saturate: got %0d want <=75", u_dut6.reveal_h_q);
    end
  endtask

  task automatic test_pixels();
    logic [11:0] g, g6;
    probe(230, 302, g, g6);
    n_cmp++;
    if (g !== BRD) begin n_fail++; $display("FAIL px_302_230: got %h want %h", g, BRD); end
    probe(300, 400, g, g6);
    n_cmp++;
    if (g !== BOX) begin n_fail++; $display("FAIL px_400_300: got %h want %h", g, BOX); end
    probe(300, 299, g, g6);
    n_cmp++;
    if (g !== PASS) begin n_fail++; $display("FAIL px_299_300: got %h want %h", g, PASS); end
    @(negedge clk); vcount_i = 11'd300; hcount_i = 11'd400; hblnk_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rgb_a !== 12'h000) begin n_fail++; $display("FAIL hblank_over_box: got %h want 000", rgb_a); end
    hblnk_i = 1'b0;
  endtask

  task automatic test_blink();
    logic [11:0] g, g6;
    int bad;
    bad = 0;
    for (int t = 16; t <= 44; t++) begin
      tick();
      probe(300, 400, g, g6);
      n_cmp++;
      if (g !== BOX) begin n_fail++; bad++; if (bad < 4) $display("FAIL blink_on_t%0d: got %h want %h", t, g, BOX); end
    end
    tick();
    probe(300, 400, g, g6);
    n_cmp++;
    if (g !== PASS || shown_a !== 1'b1) begin
      n_fail++; $display("FAIL blink_off_t45: got rgb=%h shown=%b want %h 1", g, shown_a, PASS);
    end
    n_cmp++;
    if (g6 !== BOX) begin n_fail++; $display("FAIL static_no_blink: got %h want %h", g6, BOX); end
    for (int t = 46; t <= 74; t++) begin
      tick();
      probe(300, 400, g, g6);
      n_cmp++;
      if (g !== PASS) begin n_fail++; bad++; if (bad < 4) $display("FAIL blink_off_t%0d: got %h want %h", t, g, PASS); end
    end
    tick();
    probe(300, 400, g, g6);
    n_cmp++;
    if (g !== BOX || shown_a !== 1'b1) begin
      n_fail++; $display("FAIL blink_on_t75: got rgb=%h shown=%b want %h 1", g, shown_a, BOX);
    end
  endtask

  task automatic test_disable();
    logic [11:0] g, g6;
    @(negedge clk); enable = 1'b0;
    probe(300, 400, g, g6);
    n_cmp++;
    if (g !== BOX || g6 !== BOX) begin
      n_fail++; $display("FAIL no_tearing: got a=%h b=%h want %h", g, g6, BOX);
    end
    tick();
    n_cmp++;
    if ({active_a, shown_a, active_b, shown_b} !== 4'b0000) begin
      n_fail++; $display("FAIL disable_from_show: got %b%b%b%b want 0000", active_a, shown_a, active_b, shown_b);
    end
    probe(300, 400, g, g6);
    n_cmp++;
    if (g !== PASS) begin n_fail++; $display("FAIL idle_passthrough: got %h want %h", g, PASS); end
    enable = 1'b1;
    tick(); tick();
    enable = 1'b0;
    tick();
    n_cmp++;
    if (active_a !== 1'b0) begin n_fail++; $display("FAIL disable_from_reveal: got %b want 0", active_a); end
    enable = 1'b1;
    tick();
    probe(294, 400, g, g6);
    n_cmp++;
    if (g !== PASS) begin n_fail++; $display("FAIL restart_row294: got %h want %h", g, PASS); end
    probe(295, 400, g, g6);
    n_cmp++;
    if (g !== BOX) begin n_fail++; $display("FAIL restart_row295: got %h want %h", g, BOX); end
    enable = 1'b0;
    tick();
    n_cmp++;
    if ({active_b, shown_b} !== 2'b00) begin
      n_fail++; $display("FAIL idle_wins_at_completion: got act=%b shown=%b want 0 0", active_b, shown_b);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] g, g6;
    enable = 1'b1;
    for (int t = 1; t <= 15; t++) tick();
    n_cmp++;
    if (shown_a !== 1'b1) begin n_fail++; $display("FAIL reshow_before_reset: got %b want 1", shown_a); end
    @(negedge clk); vcount_i = 11'd300; hcount_i = 11'd400; rgb_i = PASS; hsync_i = 1'b1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vcount_a, hcount_a, hsync_a, rgb_a, active_a, shown_a, active_b} !== '0) begin
      n_fail++; $display("FAIL async_reset_clear: got v=%0d h=%0d rgb=%h act=%b shown=%b",
                         vcount_a, hcount_a, rgb_a, active_a, shown_a);
    end
    @(negedge clk); rst_n = 1'b1; hsync_i = 1'b0;
    probe(300, 400, g, g6);
    n_cmp++;
    if (g !== PASS || active_a !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_idle: got rgb=%h act=%b want %h 0", g, active_a, PASS);
    end
    tick();
    probe(294, 400, g, g6);
    n_cmp++;
    if (g !== PASS) begin n_fail++; $display("FAIL after_reset_row294: got %h want %h", g, PASS); end
    probe(295, 400, g, g6);
    n_cmp++;
    if (g !== BOX || shown_a !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_row295: got rgb=%h shown=%b want %h 0", g, shown_a, BOX);
    end
  endtask

  initial begin
    test_reset();
    test_reveal();
    test_pixels();
    test_blink();
    test_disable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
